// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access
//  Description : Memory-access pipeline stage. Accepts one load/store at a
//                time, checks alignment, issues a single data-bus request,
//                waits for data_ok, then aligns and extends the load result.
//                Non-memory instructions and misaligned accesses complete in
//                the same cycle without touching the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access (
  input  logic        clk,
  input  logic        reset,          // asynchronous, active-low
  input  logic        in_valid,
  input  logic        in_memread,
  input  logic        in_memwrite,
  input  logic [63:0] in_addr,
  input  logic [2:0]  in_size,
  input  logic        in_unsigned,
  input  logic [63:0] in_wdata,
  output logic        stall,
  output logic        out_valid,
  output logic [63:0] readdata,
  output logic        out_misalign,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [7:0]  strobe_q, strobe_d;
  logic [63:0] wdata_q, wdata_d;
  logic        load_q, load_d;
  logic        unsigned_q, unsigned_d;
  logic [2:0]  off_q, off_d;
  logic [63:0] rdata_q, rdata_d;

  logic        w_mem_op;
  logic [2:0]  w_align_mask;
  logic        w_misalign;
  logic [7:0]  w_base_strobe;
  logic [7:0]  w_strobe;
  logic [63:0] w_wdata_shift;
  logic [63:0] w_load_raw;
  logic [63:0] w_load_ext;
  logic        w_load_sign;

  // The bus handshake completes on data_ok alone; addr_ok carries no meaning here.
  logic unused_addr_ok;
  assign unused_addr_ok = dresp_addr_ok;

  assign w_mem_op      = in_memread | in_memwrite;
  assign w_misalign    = |(in_addr[2:0] & w_align_mask);
  // Loads never assert byte enables; both-high is treated as a load.
  assign w_strobe      = in_memread ? 8'h00 : (w_base_strobe << in_addr[2:0]);
  assign w_wdata_shift = in_wdata << {in_addr[2:0], 3'b000};
  assign w_load_raw    = dresp_data >> {off_q, 3'b000};
  assign w_load_sign   = ~unsigned_q;

  // Alignment mask and byte-enable pattern for the requested access size.
  always_comb begin
    w_align_mask  = 3'b111;
    w_base_strobe = 8'hFF;
    case (in_size)
      3'd0: begin w_align_mask = 3'b000; w_base_strobe = 8'h01; end
      3'd1: begin w_align_mask = 3'b001; w_base_strobe = 8'h03; end
      3'd2: begin w_align_mask = 3'b011; w_base_strobe = 8'h0F; end
      default: begin w_align_mask = 3'b111; w_base_strobe = 8'hFF; end
    endcase
  end

  // Truncate the right-aligned response to the access size and extend it.
  always_comb begin
    w_load_ext = w_load_raw;
    case (size_q)
      3'd0: w_load_ext = {{56{w_load_sign & w_load_raw[7]}},  w_load_raw[7:0]};
      3'd1: w_load_ext = {{48{w_load_sign & w_load_raw[15]}}, w_load_raw[15:0]};
      3'd2: w_load_ext = {{32{w_load_sign & w_load_raw[31]}}, w_load_raw[31:0]};
      default: w_load_ext = w_load_raw;
    endcase
  end

  // Next-state logic and outputs; all outputs are forced low while reset is held.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    strobe_d     = strobe_q;
    wdata_d      = wdata_q;
    load_d       = load_q;
    unsigned_d   = unsigned_q;
    off_d        = off_q;
    rdata_d      = rdata_q;
    stall        = 1'b0;
    out_valid    = 1'b0;
    readdata     = 64'd0;
    out_misalign = 1'b0;
    dreq_valid   = 1'b0;
    dreq_addr    = 64'd0;
    dreq_size    = 3'd0;
    dreq_strobe  = 8'd0;
    dreq_data    = 64'd0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!w_mem_op) begin
            out_valid = 1'b1;
          end else if (w_misalign) begin
            out_valid    = 1'b1;
            out_misalign = 1'b1;
          end else begin
            stall      = 1'b1;
            addr_d     = in_addr;
            size_d     = in_size;
            strobe_d   = w_strobe;
            wdata_d    = w_wdata_shift;
            load_d     = in_memread;
            unsigned_d = in_unsigned;
            off_d      = in_addr[2:0];
            state_d    = BUSY;
          end
        end
      end
      BUSY: begin
        stall       = 1'b1;
        dreq_valid  = 1'b1;
        dreq_addr   = addr_q;
        dreq_size   = size_q;
        dreq_strobe = strobe_q;
        dreq_data   = wdata_q;
        if (dresp_data_ok) begin
          rdata_d = load_q ? w_load_ext : 64'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        readdata  = rdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!reset) begin
      stall        = 1'b0;
      out_valid    = 1'b0;
      readdata     = 64'd0;
      out_misalign = 1'b0;
      dreq_valid   = 1'b0;
      dreq_addr    = 64'd0;
      dreq_size    = 3'd0;
      dreq_strobe  = 8'd0;
      dreq_data    = 64'd0;
    end
  end

  // State and captured request/response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= 64'd0;
      size_q     <= 3'd0;
      strobe_q   <= 8'd0;
      wdata_q    <= 64'd0;
      load_q     <= 1'b0;
      unsigned_q <= 1'b0;
      off_q      <= 3'd0;
      rdata_q    <= 64'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      strobe_q   <= strobe_d;
      wdata_q    <= wdata_d;
      load_q     <= load_d;
      unsigned_q <= unsigned_d;
      off_q      <= off_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: the upstream instruction is valid; upstream holds all in_* stable while stall=1.
REQ-004 SHALL have ports in_memread and in_memwrite, input, 1 bit each: load or store request; both high is illegal.
REQ-005 SHALL have port in_addr, input, 64 bits: byte address.
REQ-006 SHALL have port in_size, input, 3 bits: 0=byte, 1=half, 2=word, 3=dword; 4-7 are illegal.
REQ-007 SHALL have port in_unsigned, input, 1 bit: zero-extend load data; sign-extend when 0.
REQ-008 SHALL have port in_wdata, input, 64 bits: store data, right-aligned.
REQ-009 SHALL have port stall, output, 1 bit: hold upstream and downstream pipeline registers.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid this cycle.
REQ-011 SHALL have port readdata, output, 64 bits: aligned and extended load result delivered to writeback.
REQ-012 SHALL have port out_misalign, output, 1 bit: address not aligned to in_size.
REQ-013 SHALL have outputs dreq_valid (1), dreq_addr (64), dreq_size (3), dreq_strobe (8) and dreq_data (64): the data-bus request.
REQ-014 SHALL have inputs dresp_addr_ok (1), dresp_data_ok (1) and dresp_data (64): the data-bus response.

Function
REQ-015 SHALL implement the FSM states IDLE, BUSY and DONE; the reset state SHALL be IDLE.
REQ-016 In IDLE with in_valid=1, neither memread nor memwrite set: SHALL drive stall=0, out_valid=1, readdata=0, out_misalign=0 in the same cycle.
REQ-017 The access SHALL be misaligned when in_addr[2:0] mod 2^in_size != 0.
REQ-018 In IDLE with in_valid=1, a memory op and a misaligned address: SHALL issue no request, and SHALL drive stall=0, out_valid=1, out_misalign=1 in the same cycle.
REQ-019 In IDLE with in_valid=1, a memory op and an aligned address: SHALL drive stall=1, register the request fields and the load attributes (size, unsigned, addr[2:0]), and go to BUSY.
REQ-020 In BUSY: SHALL drive dreq_valid=1 and stall=1, with all dreq_* fields constant until the cycle in which dresp_data_ok=1.
REQ-021 dresp_addr_ok SHALL be ignored; dreq_valid SHALL stay high through the dresp_data_ok cycle and deassert the next cycle.
REQ-022 When dresp_data_ok=1 in BUSY: SHALL capture the result into readdata (zero for stores) and go to DONE.
REQ-023 In DONE: SHALL drive out_valid=1 and stall=0, issue no request, and return to IDLE unconditionally on the next edge.
REQ-024 Latency: acceptance in cycle T with data_ok k cycles after the first dreq_valid cycle (k>=0) SHALL give DONE, and therefore out_valid, in cycle T+2+k.
REQ-025 dreq_addr SHALL equal in_addr, and dreq_size SHALL equal in_size.
REQ-026 Strobe SHALL be 8'h01, 8'h03, 8'h0F or 8'hFF (by size) shifted left by in_addr[2:0]; loads SHALL drive strobe 8'h00.
REQ-027 dreq_data SHALL equal in_wdata shifted left by 8*in_addr[2:0], truncated to 64 bits.
REQ-028 Load data SHALL be dresp_data shifted right by 8*addr[2:0], truncated to 8/16/32/64 bits, then zero- or sign-extended to 64 bits per in_unsigned.
REQ-029 dresp_data_ok in IDLE or DONE SHALL be ignored.
REQ-030 out_valid SHALL be 0 in IDLE when in_valid=0, and in BUSY.

Reset
REQ-031 reset=0 SHALL force IDLE immediately, without waiting for a clock edge.
REQ-032 During reset, all outputs SHALL be 0: dreq_valid, dreq_*, stall, out_valid, readdata, out_misalign.
REQ-033 A reset in BUSY SHALL abandon the transaction; its late dresp_data_ok SHALL be discarded per REQ-029.
REQ-034 Deassertion of reset SHALL be sampled synchronously; the first accept SHALL be possible on the first edge after release.

Verification
REQ-035 Signed byte load: lb at 0x1003 with dresp_data=0x0000_0000_8000_0000 and data_ok on the first request cycle -> readdata=0xFFFF_FFFF_FFFF_FF80, out_valid exactly at T+2.
REQ-036 Unsigned halfword load: lhu at 0x1006 with dresp_data=0xBEEF_0000_0000_0000 and 3 wait cycles -> readdata=0x0000_0000_0000_BEEF at T+5; stall=1 for T..T+4.
REQ-037 Word store: sw at 0x2004 with in_wdata=0x1234_5678 -> dreq_strobe=0xF0, dreq_data=0x1234_5678_0000_0000; dreq_valid high until data_ok; readdata=0.
REQ-038 Misaligned load: lw at 0x3002 -> dreq_valid never asserted; out_misalign=1, out_valid=1, stall=0 in the same cycle.
REQ-039 Reset mid-operation: reset=0 in BUSY -> dreq_valid and stall fall without waiting for a clock edge; a later dresp_data_ok=1 produces no out_valid.
REQ-040 Back-to-back traffic: ALU op, then ld, then ALU op -> out_valid for each instruction, in order, with no duplicate bus request.
